// File: rtl/video_pkg.sv
// Shared definitions for the text-mode video adapter register front-end.
// Holds the port offsets inside the adapter IO window, the default mode
// register values for the MDA and CGA adapters, the register select
// enumeration and the address decode helper used by isa_video_regs.
package video_pkg;

  // Offsets from the window base (3B0 for MDA, 3D0 for CGA).
  localparam logic [3:0] CRTC_IDX = 4'h4;
  localparam logic [3:0] CRTC_DAT = 4'h5;
  localparam logic [3:0] MODE     = 4'h8;
  localparam logic [3:0] COLOR    = 4'h9;
  localparam logic [3:0] STATUS   = 4'hA;
  localparam logic [3:0] LPEN_CLR = 4'hB;
  localparam logic [3:0] LPEN_SET = 4'hC;

  // Power-up mode register values.
  localparam logic [7:0] MDA_MODE_RESET = 8'h28;
  localparam logic [7:0] CGA_MODE_RESET = 8'h2C;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_CRTC,
    SEL_MODE,
    SEL_COLOR,
    SEL_STATUS,
    SEL_LPEN_CLR,
    SEL_LPEN_SET
  } reg_sel_e;

  // Maps an ISA address onto the register it selects. The CRTC pair is
  // matched on the 8-port block only (upper address bits), the remaining
  // registers on the full address. Colour select and light-pen set exist
  // only in the CGA map. A high aen (DMA cycle) blocks every decode.
  function automatic reg_sel_e decode_reg(input logic [15:0] base,
                                          input logic        cga,
                                          input logic [15:0] addr,
                                          input logic        aen);
    reg_sel_e sel;
    sel = SEL_NONE;
    if (!aen) begin
      if ((addr[15:3] == base[15:3]) &&
          ((addr[2:0] == CRTC_IDX[2:0]) || (addr[2:0] == CRTC_DAT[2:0])))
        sel = SEL_CRTC;
      else if (addr == base + {12'h000, MODE})
        sel = SEL_MODE;
      else if (cga && (addr == base + {12'h000, COLOR}))
        sel = SEL_COLOR;
      else if (addr == base + {12'h000, STATUS})
        sel = SEL_STATUS;
      else if (addr == base + {12'h000, LPEN_CLR})
        sel = SEL_LPEN_CLR;
      else if (cga && (addr == base + {12'h000, LPEN_SET}))
        sel = SEL_LPEN_SET;
    end
    return sel;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous level, plus an edge-detect
// stage that produces single-cycle rise/fall pulses on the synced level.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   d           asynchronous input level
//   q           synchronised level (2 flops behind d)
//   rise, fall  one-cycle pulses when q changes 0->1 / 1->0
// INIT is the idle level of the input; all stages reset to it so that no
// spurious edge is reported when reset is released.
module sync_edge #(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic meta_reg;
  logic sync_reg;
  logic prev_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_reg <= INIT;
      sync_reg <= INIT;
      prev_reg <= INIT;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
    end
  end

  assign q    = sync_reg;
  assign rise = sync_reg & ~prev_reg;
  assign fall = ~sync_reg & prev_reg;

endmodule

// File: rtl/isa_video_regs.sv
// ISA register front-end and blink timebase for the MDA/CGA text adapters.
// Decodes the 3Bx (MDA) or 3Dx (CGA) IO window, synchronises the ISA
// strobes, holds the mode / colour-select / light-pen registers, builds
// the status byte and generates the frame-based cursor and character
// blink phases.
// Ports:
//   clk, reset                 pixel clock, synchronous active-high reset
//   bus_a, bus_d, bus_aen      ISA address, write data, DMA address enable
//   bus_ior_l, bus_iow_l       ISA IO strobes (asynchronous, active-low)
//   bus_out, bus_dir           read data and read-drive enable
//   crtc_cs/a0/read/write      crtc6845 access; read/write synchronised
//   crtc_bus_out               crtc6845 read data
//   vsync, hsync, display_enable, video   timing/pixel feedback
//   crtc_mem_addr              current CRTC address (light-pen latch source)
//   lpen_in                    asynchronous light-pen trigger
//   mode_reg, color_reg        mode control and colour select registers
//   lpen_addr                  latched light-pen address
//   blink_cursor, blink_char   blink phases
module isa_video_regs
  import video_pkg::*;
#(
  parameter logic [15:0] IO_BASE_ADDR = 16'h3B0,
  parameter int          CGA_MODE     = 0,
  parameter logic [7:0]  MODE_RESET   = 8'h28,
  parameter int          BLINK_FRAMES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bus_a,
  input  logic        bus_ior_l,
  input  logic        bus_iow_l,
  input  logic        bus_aen,
  input  logic [7:0]  bus_d,
  output logic [7:0]  bus_out,
  output logic        bus_dir,
  output logic        crtc_cs,
  output logic        crtc_a0,
  output logic        crtc_read,
  output logic        crtc_write,
  input  logic [7:0]  crtc_bus_out,
  input  logic        vsync,
  input  logic        hsync,
  input  logic        display_enable,
  input  logic        video,
  input  logic [13:0] crtc_mem_addr,
  input  logic        lpen_in,
  output logic [7:0]  mode_reg,
  output logic [7:0]  color_reg,
  output logic [13:0] lpen_addr,
  output logic        blink_cursor,
  output logic        blink_char
);

  localparam logic IS_CGA = (CGA_MODE != 0);
  localparam int   FCW    = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FCW-1:0] FRAME_LAST = FCW'(BLINK_FRAMES - 1);
  localparam logic [FCW-1:0] FRAME_HALF = FCW'(BLINK_FRAMES / 2 - 1);

  // Synchroniser lanes: 0 = ior_l, 1 = iow_l, 2 = lpen_in, 3 = vsync.
  localparam int         NSYNC     = 4;
  localparam logic [3:0] SYNC_INIT = 4'b0011;

  logic [NSYNC-1:0] sync_d;
  logic [NSYNC-1:0] sync_q;
  logic [NSYNC-1:0] sync_rise;
  logic [NSYNC-1:0] sync_fall;

  assign sync_d = {vsync, lpen_in, bus_iow_l, bus_ior_l};

  generate
    for (genvar gi = 0; gi < NSYNC; gi++) begin : g_sync
      sync_edge #(
        .INIT (SYNC_INIT[gi])
      ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (sync_d[gi]),
        .q     (sync_q[gi]),
        .rise  (sync_rise[gi]),
        .fall  (sync_fall[gi])
      );
    end
  endgenerate

  logic ior_sync;
  logic iow_sync;
  logic iow_fall;
  logic lpen_sw;
  logic lpen_rise;
  logic vsync_rise;

  assign ior_sync   = sync_q[0];
  assign iow_sync   = sync_q[1];
  assign iow_fall   = sync_fall[1];
  assign lpen_sw    = sync_q[2];
  assign lpen_rise  = sync_rise[2];
  assign vsync_rise = sync_rise[3];

  logic unused_edges;
  assign unused_edges = &{1'b0, sync_rise[1:0], sync_fall[0], sync_fall[3:2]};

  reg_sel_e sel;
  assign sel = decode_reg(IO_BASE_ADDR, IS_CGA, bus_a, bus_aen);

  // The strobe synchronisers reset to the idle (high) level, so a strobe
  // held low across reset would look like a fresh falling edge once reset
  // lifts. Commits stay disarmed until the synced strobe has been seen high
  // with real samples in both sync stages (two cycles after reset).
  logic [1:0] rst_pipe_reg;
  logic       iow_armed_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      rst_pipe_reg  <= 2'b11;
      iow_armed_reg <= 1'b0;
    end else begin
      rst_pipe_reg  <= {rst_pipe_reg[0], 1'b0};
      if ((rst_pipe_reg == 2'b00) && iow_sync)
        iow_armed_reg <= 1'b1;
    end
  end

  logic commit;
  logic wr_mode;
  logic wr_color;
  logic wr_lpen_clr;
  logic wr_lpen_set;

  assign commit      = iow_fall & iow_armed_reg;
  assign wr_mode     = commit & (sel == SEL_MODE);
  assign wr_color    = commit & (sel == SEL_COLOR);
  assign wr_lpen_clr = commit & (sel == SEL_LPEN_CLR);
  assign wr_lpen_set = commit & (sel == SEL_LPEN_SET);

  logic lpen_flag_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_reg      <= MODE_RESET;
      color_reg     <= 8'h00;
      lpen_addr     <= 14'h0000;
      lpen_flag_reg <= 1'b0;
    end else begin
      if (wr_mode)
        mode_reg <= bus_d;
      if (wr_color)
        color_reg <= bus_d;
      // A clear on the same cycle as a pen edge wins and the edge is lost;
      // a set write and an edge together give a single latch.
      if (wr_lpen_clr) begin
        lpen_flag_reg <= 1'b0;
      end else if (wr_lpen_set || (lpen_rise && !lpen_flag_reg)) begin
        lpen_addr     <= crtc_mem_addr;
        lpen_flag_reg <= 1'b1;
      end
    end
  end

  // Blink timebase: the cursor phase flips at the half-way frame and at the
  // wrap, the character phase at the wrap only.
  logic [FCW-1:0] frame_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_reg <= '0;
      blink_cursor  <= 1'b0;
      blink_char    <= 1'b0;
    end else if (vsync_rise) begin
      if (frame_cnt_reg == FRAME_LAST) begin
        frame_cnt_reg <= '0;
        blink_cursor  <= ~blink_cursor;
        blink_char    <= ~blink_char;
      end else begin
        frame_cnt_reg <= frame_cnt_reg + 1'b1;
        if (frame_cnt_reg == FRAME_HALF)
          blink_cursor <= ~blink_cursor;
      end
    end
  end

  // Read path is combinational from the raw ior_l so bus_dir meets ISA
  // timing; only the CRTC handshake uses the synced strobes.
  logic [7:0] status_byte;

  assign status_byte = IS_CGA ? {4'hF, vsync, lpen_sw, lpen_flag_reg, ~display_enable}
                              : {4'hF, video, 2'b00, hsync};

  assign crtc_cs    = (sel == SEL_CRTC);
  assign crtc_a0    = bus_a[0];
  assign crtc_read  = crtc_cs & ~ior_sync;
  assign crtc_write = crtc_cs & ~iow_sync;
  assign bus_dir    = (crtc_cs | (sel == SEL_STATUS)) & ~bus_ior_l;

  always_comb begin
    bus_out = 8'h00;
    if (sel == SEL_STATUS)
      bus_out = status_byte;
    else if (crtc_cs && crtc_a0)
      bus_out = crtc_bus_out;
  end

endmodule

// File: tb/tb_isa_video_regs.sv
// Directed bench for isa_video_regs: one MDA instance (3B0) and one CGA
// instance (3D0) share the ISA bus and timing inputs.
module tb_isa_video_regs;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] bus_a = 16'h0000;
  logic        bus_ior_l = 1'b1;
  logic        bus_iow_l = 1'b1;
  logic        bus_aen = 1'b0;
  logic [7:0]  bus_d = 8'h00;
  logic [7:0]  crtc_bus_out = 8'h00;
  logic        vsync = 1'b0;
  logic        hsync = 1'b0;
  logic        display_enable = 1'b1;
  logic        video = 1'b0;
  logic [13:0] crtc_mem_addr = 14'h0000;
  logic        lpen_in = 1'b0;

  logic [7:0]  m_bus_out, c_bus_out;
  logic        m_bus_dir, c_bus_dir;
  logic        m_cs, m_a0, m_rd, m_wr, c_cs, c_a0, c_rd, c_wr;
  logic [7:0]  m_mode, m_color, c_mode, c_color;
  logic [13:0] m_lpen, c_lpen;
  logic        m_bcur, m_bchr, c_bcur, c_bchr;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  isa_video_regs #(
    .IO_BASE_ADDR (16'h3B0), .CGA_MODE (0), .MODE_RESET (8'h28), .BLINK_FRAMES (16)
  ) u_mda (
    .clk (clk), .reset (reset), .bus_a (bus_a), .bus_ior_l (bus_ior_l),
    .bus_iow_l (bus_iow_l), .bus_aen (bus_aen), .bus_d (bus_d),
    .bus_out (m_bus_out), .bus_dir (m_bus_dir), .crtc_cs (m_cs), .crtc_a0 (m_a0),
    .crtc_read (m_rd), .crtc_write (m_wr), .crtc_bus_out (crtc_bus_out),
    .vsync (vsync), .hsync (hsync), .display_enable (display_enable), .video (video),
    .crtc_mem_addr (crtc_mem_addr), .lpen_in (lpen_in), .mode_reg (m_mode),
    .color_reg (m_color), .lpen_addr (m_lpen), .blink_cursor (m_bcur), .blink_char (m_bchr)
  );

  isa_video_regs #(
    .IO_BASE_ADDR (16'h3D0), .CGA_MODE (1), .MODE_RESET (8'h2C), .BLINK_FRAMES (16)
  ) u_cga (
    .clk (clk), .reset (reset), .bus_a (bus_a), .bus_ior_l (bus_ior_l),
    .bus_iow_l (bus_iow_l), .bus_aen (bus_aen), .bus_d (bus_d),
    .bus_out (c_bus_out), .bus_dir (c_bus_dir), .crtc_cs (c_cs), .crtc_a0 (c_a0),
    .crtc_read (c_rd), .crtc_write (c_wr), .crtc_bus_out (crtc_bus_out),
    .vsync (vsync), .hsync (hsync), .display_enable (display_enable), .video (video),
    .crtc_mem_addr (crtc_mem_addr), .lpen_in (lpen_in), .mode_reg (c_mode),
    .color_reg (c_color), .lpen_addr (c_lpen), .blink_cursor (c_bcur), .blink_char (c_bchr)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      pass_cnt++;
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Full IO write: strobe held 4 clocks, then 3 idle clocks.
  task automatic io_write(input logic [15:0] addr, input logic [7:0] data);
    tick(1);
    bus_a = addr;
    bus_d = data;
    bus_iow_l = 1'b0;
    tick(4);
    bus_iow_l = 1'b1;
    tick(3);
  endtask

  // Start a read strobe; caller samples then calls io_read_end.
  task automatic io_read_start(input logic [15:0] addr);
    tick(1);
    bus_a = addr;
    bus_ior_l = 1'b0;
    #1;
  endtask

  task automatic io_read_end();
    bus_ior_l = 1'b1;
    tick(2);
  endtask

  task automatic vsync_pulse();
    tick(1);
    vsync = 1'b1;
    tick(3);
    vsync = 1'b0;
    tick(3);
  endtask

  initial begin
    // Reset state
    tick(3);
    reset = 1'b0;
    tick(1);
    check("rst_mda_mode",  16'(m_mode),  16'h0028);
    check("rst_cga_mode",  16'(c_mode),  16'h002C);
    check("rst_cga_color", 16'(c_color), 16'h0000);
    check("rst_cga_lpen",  16'(c_lpen),  16'h0000);
    check("rst_blink",     16'({m_bcur, m_bchr}), 16'h0000);
    tick(4);

    // Write latency and single commit over a long strobe
    bus_a = 16'h03B8;
    bus_d = 8'h29;
    tick(1);
    bus_iow_l = 1'b0;
    tick(2);
    check("wr_lat_2clk", 16'(m_mode), 16'h0028);
    tick(1);
    check("wr_lat_3clk", 16'(m_mode), 16'h0029);
    tick(6);
    bus_d = 8'h55;
    tick(11);
    bus_iow_l = 1'b1;
    tick(4);
    check("wr_one_commit", 16'(m_mode), 16'h0029);
    check("wr_cga_untouched", 16'(c_mode), 16'h002C);

    // CRTC write strobe timing
    bus_a = 16'h03B5;
    bus_d = 8'h12;
    tick(1);
    bus_iow_l = 1'b0;
    #1;
    check("crtc_cs", 16'({m_cs, m_a0}), 16'h0003);
    tick(1);
    check("crtc_wr_lag1", 16'(m_wr), 16'h0000);
    tick(1);
    check("crtc_wr_lag2", 16'(m_wr), 16'h0001);
    bus_iow_l = 1'b1;
    tick(4);
    check("crtc_wr_end", 16'(m_wr), 16'h0000);

    // MDA reads
    video = 1'b1;
    hsync = 1'b1;
    io_read_start(16'h03BA);
    check("rd_mda_status", 16'({m_bus_dir, m_bus_out}), 16'h01F9);
    io_read_end();
    io_read_start(16'h03BC);
    check("rd_mda_3bc", 16'({m_bus_dir, m_bus_out}), 16'h0000);
    io_read_end();
    crtc_bus_out = 8'hA5;
    io_read_start(16'h03B5);
    check("rd_crtc_dat", 16'({m_bus_dir, m_bus_out}), 16'h01A5);
    check("crtc_rd_lag0", 16'(m_rd), 16'h0000);
    tick(2);
    check("crtc_rd_lag2", 16'(m_rd), 16'h0001);
    io_read_end();
    video = 1'b0;
    hsync = 1'b0;

    // CGA colour select and status
    io_write(16'h03D9, 8'h3F);
    check("cga_color", 16'(c_color), 16'h003F);
    check("mda_color_zero", 16'(m_color), 16'h0000);
    vsync = 1'b1;
    display_enable = 1'b0;
    io_read_start(16'h03DA);
    check("rd_cga_status", 16'({c_bus_dir, c_bus_out}), 16'h01F9);
    io_read_end();
    vsync = 1'b0;
    display_enable = 1'b1;

    // Light pen
    crtc_mem_addr = 14'h0123;
    lpen_in = 1'b1;
    tick(4);
    check("lpen_latch", 16'(c_lpen), 16'h0123);
    io_read_start(16'h03DA);
    check("lpen_status_hi", 16'(c_bus_out), 16'h00F6);
    io_read_end();
    lpen_in = 1'b0;
    tick(4);
    crtc_mem_addr = 14'h0456;
    lpen_in = 1'b1;
    tick(4);
    lpen_in = 1'b0;
    tick(4);
    check("lpen_second_ignored", 16'(c_lpen), 16'h0123);
    io_read_start(16'h03DA);
    check("lpen_flag_held", 16'(c_bus_out), 16'h00F2);
    io_read_end();
    io_write(16'h03DB, 8'h00);
    io_read_start(16'h03DA);
    check("lpen_cleared", 16'(c_bus_out), 16'h00F0);
    io_read_end();
    crtc_mem_addr = 14'h0789;
    io_write(16'h03DC, 8'h00);
    check("lpen_set_addr", 16'(c_lpen), 16'h0789);
    io_read_start(16'h03DA);
    check("lpen_set_flag", 16'(c_bus_out), 16'h00F2);
    io_read_end();

    // DMA cycle blocks the decode
    bus_aen = 1'b1;
    io_write(16'h03B8, 8'h77);
    bus_aen = 1'b0;
    check("aen_block", 16'(m_mode), 16'h0029);

    // Reset in the middle of a write strobe
    bus_a = 16'h03B8;
    bus_d = 8'h44;
    tick(1);
    bus_iow_l = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    check("rst_mid_value", 16'(m_mode), 16'h0028);
    tick(8);
    check("rst_mid_nocommit", 16'(m_mode), 16'h0028);
    bus_iow_l = 1'b1;
    tick(4);
    check("rst_mid_after_rise", 16'(m_mode), 16'h0028);
    io_write(16'h03B8, 8'h44);
    check("rst_mid_next_write", 16'(m_mode), 16'h0044);

    // Blink timebase over 64 frames
    for (int n = 1; n <= 64; n++) begin
      vsync_pulse();
      if (n == 7)
        check("blink_f7", 16'({m_bcur, m_bchr}), 16'h0000);
      if ((n % 8) == 0)
        check($sformatf("blink_f%0d", n), 16'({m_bcur, m_bchr}),
              16'({1'(((n / 8) % 2) != 0), 1'(((n / 16) % 2) != 0)}));
    end
    check("blink_cga_end", 16'({c_bcur, c_bchr}), 16'h0000);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
